sync_debounce_edge: RTL and testbench

//  Multi-channel input conditioner for the io_circuits block.

---
 rtl/sync_debounce_edge.sv | 146 ++++++++++++++
 tb/tb_sync_debounce_edge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// -----------------------------------------------------------------------------
// sync_debounce_edge
//
// Multi-channel input conditioner placed between board pins (buttons/switches)
// and core logic. Each channel goes through three stages:
//   1. an N-flop synchronizer,
//   2. a saturating debouncer that advances once per shared sample tick,
//   3. a rising-edge detector that emits a one-cycle pulse per press.
//
// Parameters
//   WIDTH           number of independent input channels
//   SYNC_STAGES     synchronizer flop depth (>= 2)
//   SAMPLE_CNT_MAX  clk cycles per debounce sample tick (>= 1)
//   PULSE_CNT_MAX   consecutive high samples needed to declare a press (>= 1)
//
// Ports
//   clk               system clock
//   rst               synchronous reset, active-high
//   async_signal      raw asynchronous inputs            [WIDTH]
//   sync_signal       last synchronizer stage            [WIDTH]
//   debounced_signal  registered debounced level         [WIDTH]
//   edge_pulse        1-cycle pulse on debounced rise    [WIDTH]
//   fall_pulse        1-cycle pulse on debounced fall    [WIDTH]
//                     (present only when SYNC_DEBOUNCE_FALL_EN is defined)
//
// Build option
//   SYNC_DEBOUNCE_FALL_EN  adds the fall_pulse output and its logic.
// -----------------------------------------------------------------------------
module sync_debounce_edge #(
  parameter int WIDTH          = 1,
  parameter int SYNC_STAGES    = 2,
  parameter int SAMPLE_CNT_MAX = 25000,
  parameter int PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_signal,
  output logic [WIDTH-1:0] sync_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] edge_pulse
`ifdef SYNC_DEBOUNCE_FALL_EN
  ,
  output logic [WIDTH-1:0] fall_pulse
`endif
);

  localparam int TW = $clog2(SAMPLE_CNT_MAX + 1);
  localparam int CW = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(PULSE_CNT_MAX);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [TW-1:0]    r_tick_cnt;
  logic             w_tick;
  logic [CW-1:0]    r_cnt      [WIDTH];
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_prev;

  // ---------------------------------------------------------------------------
  // Synchronizer chain: stage 0 samples the pin, the last stage is sync_signal.
  // ---------------------------------------------------------------------------
  // NOTE: the chain is a small flop array, not a RAM, so it is cleared on
  // reset like any other state; this keeps all outputs at 0 right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage take the previous
      // stage's old value, so this really is a shift by one per clock.
      r_sync[0] <= async_signal;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared sample tick: counts 0..SAMPLE_CNT_MAX-1, tick on the last count.
  // With SAMPLE_CNT_MAX=1 the counter stays at 0 and tick is always high.
  // ---------------------------------------------------------------------------
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel saturating counters. A low synchronized input clears the
  // counter on any cycle and takes priority over the tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      // NOTE: default first so every path assigns w_cnt_next -- no latch.
      w_cnt_next[i] = r_cnt[i];
      if (!r_sync[SYNC_STAGES-1][i]) begin
        w_cnt_next[i] = '0;
      end else if (w_tick && (r_cnt[i] != CNT_MAX)) begin
        w_cnt_next[i] = r_cnt[i] + CW'(1);
      end
    end
  end

  // The debounced level compares the next counter value, so it falls in the
  // same edge that clears the counter (one cycle after sync_signal drops) and
  // rises in the same edge that makes the counter saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
      r_deb  <= '0;
      r_prev <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
        r_deb[i] <= (w_cnt_next[i] == CNT_MAX);
      end
      r_prev <= r_deb;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Pulses are decoded from two registers, so each is exactly one
  // cycle wide and cannot repeat on consecutive cycles.
  // ---------------------------------------------------------------------------
  assign sync_signal      = r_sync[SYNC_STAGES-1];
  assign debounced_signal = r_deb;
  assign edge_pulse       = r_deb & ~r_prev;

`ifdef SYNC_DEBOUNCE_FALL_EN
  assign fall_pulse = ~r_deb & r_prev;
`else
  // Falling-edge reporting is not built; r_prev only feeds edge_pulse.
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce_edge
//
// Bench for sync_debounce_edge with WIDTH=2, SYNC_STAGES=2, SAMPLE_CNT_MAX=4,
// PULSE_CNT_MAX=3. A cycle model predicts every output each cycle; the
// predictions queue up as stimulus is driven and are popped when the DUT
// outputs are sampled on the falling edge. A phase table adds hand-derived
// pulse counts and end levels per phase; a hand-written sequence covers the
// one-cycle drop aligned with a sample tick.
// -----------------------------------------------------------------------------
module tb_sync_debounce_edge;

  localparam int WIDTH          = 2;
  localparam int SYNC_STAGES    = 2;
  localparam int SAMPLE_CNT_MAX = 4;
  localparam int PULSE_CNT_MAX  = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] async_signal;
  logic [WIDTH-1:0] sync_signal;
  logic [WIDTH-1:0] debounced_signal;
  logic [WIDTH-1:0] edge_pulse;
`ifdef SYNC_DEBOUNCE_FALL_EN
  logic [WIDTH-1:0] fall_pulse;
`endif

  sync_debounce_edge #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC_STAGES),
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX),
    .PULSE_CNT_MAX  (PULSE_CNT_MAX)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .async_signal     (async_signal),
    .sync_signal      (sync_signal),
    .debounced_signal (debounced_signal),
    .edge_pulse       (edge_pulse)
`ifdef SYNC_DEBOUNCE_FALL_EN
    ,
    .fall_pulse       (fall_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Cycle model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] edg;
    logic [WIDTH-1:0] fall;
  } exp_t;

  exp_t sb[$];

  logic [WIDTH-1:0] m_st0  = '0;
  logic [WIDTH-1:0] m_st1  = '0;
  int               m_tick = 0;
  int               m_cnt [WIDTH];
  logic [WIDTH-1:0] m_deb  = '0;
  logic [WIDTH-1:0] m_prev = '0;

  // Predict the outputs after the next rising edge for the given inputs.
  task automatic model_step(input logic r, input logic [WIDTH-1:0] a);
    exp_t e;
    bit   tk;
    if (r) begin
      m_st0 = '0; m_st1 = '0; m_tick = 0; m_deb = '0; m_prev = '0;
      for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
    end else begin
      tk = (m_tick == SAMPLE_CNT_MAX - 1);
      for (int i = 0; i < WIDTH; i++) begin
        if (m_st1[i] == 1'b0)                  m_cnt[i] = 0;
        else if (tk && m_cnt[i] < PULSE_CNT_MAX) m_cnt[i] = m_cnt[i] + 1;
      end
      m_prev = m_deb;
      for (int i = 0; i < WIDTH; i++) m_deb[i] = (m_cnt[i] == PULSE_CNT_MAX);
      m_tick = tk ? 0 : m_tick + 1;
      m_st1  = m_st0;
      m_st0  = a;
    end
    e.sync = m_st1;
    e.deb  = m_deb;
    e.edg  = m_deb & ~m_prev;
    e.fall = ~m_deb & m_prev;
    sb.push_back(e);
  endtask

  // Observed pulse counters for the phase in progress.
  int               c_e0, c_e1, c_f0, c_f1, c_consec;
  logic [WIDTH-1:0] last_edge = '0;

  task automatic clear_counts();
    c_e0 = 0; c_e1 = 0; c_f0 = 0; c_f1 = 0; c_consec = 0;
  endtask

  // Called in the falling-edge half: drive, clock, sample, compare.
  task automatic step(input logic r, input logic [WIDTH-1:0] a);
    exp_t e;
    rst          = r;
    async_signal = a;
    model_step(r, a);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sync_signal",      32'(sync_signal),      32'(e.sync));
      check("debounced_signal", 32'(debounced_signal), 32'(e.deb));
      check("edge_pulse",       32'(edge_pulse),       32'(e.edg));
`ifdef SYNC_DEBOUNCE_FALL_EN
      check("fall_pulse",       32'(fall_pulse),       32'(e.fall));
      if (fall_pulse[0] === 1'b1) c_f0++;
      if (fall_pulse[1] === 1'b1) c_f1++;
`endif
    end
    if (edge_pulse[0] === 1'b1) c_e0++;
    if (edge_pulse[1] === 1'b1) c_e1++;
    if ((edge_pulse & last_edge) != '0) c_consec++;
    last_edge = edge_pulse;
  endtask

  // ---------------------------------------------------------------------------
  // Phase table: {rst, inputs, cycles, expected pulse counts, end level}
  // ---------------------------------------------------------------------------
  typedef struct {
    logic             r;
    logic [WIDTH-1:0] a;
    int               n;
    int               e0, e1, f0, f1;
    logic [WIDTH-1:0] deb_end;
  } row_t;

  localparam int NROWS = 12;
  row_t rows [NROWS];

  initial begin
    for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
    rst          = 1'b1;
    async_signal = '0;
    clear_counts();

    rows[0]  = '{1'b1, 2'b11, 3,  0, 0, 0, 0, 2'b00}; // reset, inputs high
    rows[1]  = '{1'b0, 2'b01, 30, 1, 0, 0, 0, 2'b01}; // ch0 held: one press
    rows[2]  = '{1'b0, 2'b00, 10, 0, 0, 1, 0, 2'b00}; // release
    rows[3]  = '{1'b0, 2'b01, 6,  0, 0, 0, 0, 2'b00}; // short bounce
    rows[4]  = '{1'b0, 2'b00, 10, 0, 0, 0, 0, 2'b00};
    rows[5]  = '{1'b0, 2'b01, 2,  0, 0, 0, 0, 2'b00}; // ch0 first ...
    rows[6]  = '{1'b0, 2'b11, 30, 1, 1, 0, 0, 2'b11}; // ... ch1 2 cycles later
    rows[7]  = '{1'b0, 2'b00, 10, 0, 0, 1, 1, 2'b00};
    rows[8]  = '{1'b0, 2'b01, 20, 1, 0, 0, 0, 2'b01}; // qualified press
    rows[9]  = '{1'b1, 2'b01, 2,  0, 0, 0, 0, 2'b00}; // reset mid-press
    rows[10] = '{1'b0, 2'b01, 20, 1, 0, 0, 0, 2'b01}; // re-qualifies once
    rows[11] = '{1'b0, 2'b00, 10, 0, 0, 1, 0, 2'b00}; // release

    @(negedge clk);
    for (int r = 0; r < NROWS; r++) begin
      clear_counts();
      for (int k = 0; k < rows[r].n; k++) step(rows[r].r, rows[r].a);
      check($sformatf("row%0d_edge0", r), 32'(c_e0), 32'(rows[r].e0));
      check($sformatf("row%0d_edge1", r), 32'(c_e1), 32'(rows[r].e1));
      check($sformatf("row%0d_deb_end", r), 32'(debounced_signal),
            32'(rows[r].deb_end));
      check($sformatf("row%0d_no_double_pulse", r), 32'(c_consec), 32'd0);
`ifdef SYNC_DEBOUNCE_FALL_EN
      check($sformatf("row%0d_fall0", r), 32'(c_f0), 32'(rows[r].f0));
      check($sformatf("row%0d_fall1", r), 32'(c_f1), 32'(rows[r].f1));
`endif
    end

    // -------------------------------------------------------------------------
    // Held press, then a single-cycle drop whose synchronized low coincides
    // with a sample tick: clear must win, debounced falls, then re-qualifies.
    // -------------------------------------------------------------------------
    begin
      int   guard;
      bit   saw_low;
      clear_counts();
      repeat (20) step(1'b0, 2'b01);
      check("drop_qualified_before", 32'(debounced_signal[0]), 32'd1);
      // Align so the dropped sample reaches the last sync stage on a tick cycle.
      guard = 0;
      while (m_tick != 1 && guard < 2 * SAMPLE_CNT_MAX) begin
        step(1'b0, 2'b01);
        guard++;
      end
      check("drop_align_bound", 32'(m_tick), 32'd1);
      step(1'b0, 2'b00);
      saw_low = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step(1'b0, 2'b01);
        if (debounced_signal[0] === 1'b0) saw_low = 1'b1;
      end
      check("drop_deb_fell", 32'(saw_low), 32'd1);
      check("drop_deb_requalified", 32'(debounced_signal[0]), 32'd1);
      repeat (10) step(1'b0, 2'b00);
      check("drop_total_edge0", 32'(c_e0), 32'd2);
      check("drop_total_edge1", 32'(c_e1), 32'd0);
      check("drop_no_double_pulse", 32'(c_consec), 32'd0);
`ifdef SYNC_DEBOUNCE_FALL_EN
      check("drop_total_fall0", 32'(c_f0), 32'd2);
`endif
    end

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
